// File: rtl/stream_demux_pkg.sv
// Shared constants and helpers for the registered 1-to-N stream demultiplexer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package stream_demux_pkg;

    // Width of the saturating discarded-word counter.
    localparam int DROP_CNT_W = 16;

    // Default instance geometry.
    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_N     = 8;

    // Saturation ceiling of the drop counter.
    localparam logic [DROP_CNT_W-1:0] DROP_CNT_MAX = '1;

    // True when a select value addresses an existing channel. Only false
    // when N is not a power of two and the select lands in the unused codes.
    function automatic logic sel_in_range(input int unsigned sel, input int unsigned n);
        return (sel < n);
    endfunction

endpackage

// File: rtl/demux_slot.sv
// Single-entry output buffer for one demux channel (valid + data register).
// Latency: a load at edge k is visible on out_valid/out_data in cycle k+1.
// Backpressure: free = !out_valid || out_ready, so a load may coincide with a drain.
module demux_slot
    import stream_demux_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] data_in,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             free
);

    // The slot accepts a new word whenever it is empty or is being emptied
    // this cycle; depends only on the local valid and downstream ready.
    assign free = !out_valid || out_ready;

    // Load wins over drain so back-to-back words stream at one per cycle;
    // data is only written on load, so the last word stays visible afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= data_in;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/stream_demux.sv
// Registered 1-to-N stream demux (unicast by in_sel or broadcast) with a one-word buffer per channel.
// Latency: word accepted at edge k appears on its channel(s) in cycle k+1; drop_pulse likewise.
// Backpressure: in_ready is combinational from en/in_sel/in_bcast and slot free flags; broadcast is all-or-nothing.
module stream_demux
    import stream_demux_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int N     = DEFAULT_N,
    // Derived from N; leave at its default.
    parameter int SEL_W = $clog2(N)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      in_data,
    input  logic [SEL_W-1:0]      in_sel,
    input  logic                  in_bcast,
    output logic [N-1:0]          out_valid,
    input  logic [N-1:0]          out_ready,
    output logic [N*WIDTH-1:0]    out_data,
    output logic                  drop_pulse,
    output logic [DROP_CNT_W-1:0] drop_count
);

    // Every code of in_sel gets a free flag; codes past N-1 read as free so
    // an out-of-range word is never stalled, it is simply discarded.
    localparam int SEL_SPAN = 1 << SEL_W;

    logic [N-1:0]        slot_free;
    logic [N-1:0]        load_vec;
    logic [SEL_SPAN-1:0] free_span;
    logic                sel_ok;
    logic                all_free;
    logic                accept;
    logic                drop;

    // Pad the per-channel free flags out to the full select code space.
    always_comb begin
        free_span          = '1;
        free_span[N-1:0]   = slot_free;
    end

    assign sel_ok   = sel_in_range(32'(in_sel), 32'(N));
    assign all_free = &slot_free;

    // Ready decode: held low in reset and when disabled; broadcast needs every
    // slot free, unicast needs only its target (or nothing when out of range).
    always_comb begin
        in_ready = 1'b0;
        if (rst_n && en) begin
            if (in_bcast) begin
                in_ready = all_free;
            end else begin
                in_ready = !sel_ok || free_span[in_sel];
            end
        end
    end

    assign accept = in_valid && in_ready;
    assign drop   = accept && !in_bcast && !sel_ok;

    // Load-enable vector: all slots on broadcast, one-hot on unicast in range.
    always_comb begin
        load_vec = '0;
        if (accept) begin
            if (in_bcast) begin
                load_vec = '1;
            end else if (sel_ok) begin
                for (int i = 0; i < N; i++) begin
                    if (in_sel == SEL_W'(i)) begin
                        load_vec[i] = 1'b1;
                    end
                end
            end
        end
    end

    // Drop pulse for the cycle after a discard, and a saturating tally of discards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_pulse <= 1'b0;
            drop_count <= '0;
        end else begin
            drop_pulse <= drop;
            if (drop && (drop_count != DROP_CNT_MAX)) begin
                drop_count <= drop_count + 1'b1;
            end
        end
    end

    // One buffer slot per output channel.
    for (genvar g = 0; g < N; g++) begin : g_slot
        demux_slot #(
            .WIDTH (WIDTH)
        ) u_slot (
            .clk       (clk),
            .rst_n     (rst_n),
            .load      (load_vec[g]),
            .data_in   (in_data),
            .out_ready (out_ready[g]),
            .out_valid (out_valid[g]),
            .out_data  (out_data[g*WIDTH +: WIDTH]),
            .free      (slot_free[g])
        );
    end

endmodule

// File: tb/tb_stream_demux.sv
// Self-checking bench for stream_demux: N=8 instance for routing/backpressure/broadcast/enable, N=6 for drops.
// Latency: inputs driven 1ns after the rising edge, ready sampled mid-cycle, outputs sampled 1ns after the next edge.
// Backpressure: exercised by per-channel out_ready patterns in the vector table.
module tb_stream_demux;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    // N = 8 instance
    logic        en, in_valid, in_ready, in_bcast;
    logic [2:0]  in_sel;
    logic [7:0]  in_data;
    logic [7:0]  out_valid, out_ready;
    logic [63:0] out_data;
    logic        drop_pulse;
    logic [15:0] drop_count;

    // N = 6 instance
    logic        d6_en, d6_in_valid, d6_in_ready, d6_in_bcast;
    logic [2:0]  d6_in_sel;
    logic [7:0]  d6_in_data;
    logic [5:0]  d6_out_valid, d6_out_ready;
    logic [47:0] d6_out_data;
    logic        d6_drop_pulse;
    logic [15:0] d6_drop_count;

    stream_demux #(.WIDTH(8), .N(8)) dut8 (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_sel     (in_sel),
        .in_bcast   (in_bcast),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .drop_pulse (drop_pulse),
        .drop_count (drop_count)
    );

    stream_demux #(.WIDTH(8), .N(6)) dut6 (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (d6_en),
        .in_valid   (d6_in_valid),
        .in_ready   (d6_in_ready),
        .in_data    (d6_in_data),
        .in_sel     (d6_in_sel),
        .in_bcast   (d6_in_bcast),
        .out_valid  (d6_out_valid),
        .out_ready  (d6_out_ready),
        .out_data   (d6_out_data),
        .drop_pulse (d6_drop_pulse),
        .drop_count (d6_drop_count)
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        string      name;
        logic       en;
        logic       vld;
        logic       bcast;
        logic [2:0] sel;
        logic [7:0] data;
        logic [7:0] ordy;
        logic       exp_rdy;
        logic [7:0] exp_vld;
        int         chk_ch;   // -1: no data check, 8: every channel, else one channel
        logic [7:0] exp_dat;
    } vec_t;

    vec_t tbl_a[$];
    vec_t tbl_b[$];

    function automatic vec_t mk(input string name, input logic e, input logic v, input logic b,
                                input logic [2:0] s, input logic [7:0] d, input logic [7:0] r,
                                input logic xr, input logic [7:0] xv, input int ch,
                                input logic [7:0] xd);
        vec_t t;
        t.name = name; t.en = e; t.vld = v; t.bcast = b; t.sel = s; t.data = d;
        t.ordy = r; t.exp_rdy = xr; t.exp_vld = xv; t.chk_ch = ch; t.exp_dat = xd;
        return t;
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Apply one vector at posedge+1, check ready mid-cycle, outputs after the edge.
    task automatic run_vec(input vec_t v);
        en = v.en; in_valid = v.vld; in_bcast = v.bcast; in_sel = v.sel;
        in_data = v.data; out_ready = v.ordy;
        #2;
        check({v.name, " in_ready"}, 64'(in_ready), 64'(v.exp_rdy));
        @(posedge clk); #1;
        check({v.name, " out_valid"}, 64'(out_valid), 64'(v.exp_vld));
        if (v.chk_ch == 8) begin
            for (int c = 0; c < 8; c++)
                check($sformatf("%s out_data[%0d]", v.name, c), 64'(out_data[c*8 +: 8]), 64'(v.exp_dat));
        end else if (v.chk_ch >= 0) begin
            check($sformatf("%s out_data[%0d]", v.name, v.chk_ch),
                  64'(out_data[v.chk_ch*8 +: 8]), 64'(v.exp_dat));
        end
    endtask

    initial begin
        int acc;

        // Unicast sweep, one channel per cycle, everything draining.
        for (int i = 0; i < 8; i++)
            tbl_a.push_back(mk($sformatf("sweep%0d", i), 1, 1, 0, 3'(i), 8'(8'hA0 + i), 8'hFF,
                               1, 8'(1 << i), i, 8'(8'hA0 + i)));
        tbl_a.push_back(mk("idle0",       1, 0, 0, 3'd0, 8'h00, 8'hFF, 1, 8'h00, -1, 8'h00));
        // Backpressure on channel 3.
        tbl_a.push_back(mk("bp_first",    1, 1, 0, 3'd3, 8'h31, 8'hF7, 1, 8'h08,  3, 8'h31));
        tbl_a.push_back(mk("bp_stall",    1, 1, 0, 3'd3, 8'h32, 8'hF7, 0, 8'h08,  3, 8'h31));
        tbl_a.push_back(mk("bp_other",    1, 1, 0, 3'd5, 8'h55, 8'hF7, 1, 8'h28,  5, 8'h55));
        tbl_a.push_back(mk("bp_release",  1, 1, 0, 3'd3, 8'h32, 8'hFF, 1, 8'h08,  3, 8'h32));
        tbl_a.push_back(mk("idle1",       1, 0, 0, 3'd3, 8'h00, 8'hFF, 1, 8'h00, -1, 8'h00));
        // Broadcast, then all-or-nothing with slot 2 stuck.
        tbl_a.push_back(mk("bcast",       1, 1, 1, 3'd0, 8'h5A, 8'hFF, 1, 8'hFF,  8, 8'h5A));
        tbl_a.push_back(mk("fill2",       1, 0, 1, 3'd0, 8'h5A, 8'hFB, 0, 8'h04,  2, 8'h5A));
        tbl_a.push_back(mk("bcast_block", 1, 1, 1, 3'd0, 8'hC3, 8'hFB, 0, 8'h04,  8, 8'h5A));
        tbl_a.push_back(mk("bcast_drain", 1, 1, 1, 3'd0, 8'hC3, 8'hFF, 1, 8'hFF,  8, 8'hC3));
        // After reset: enable low blocks input while buffered words drain.
        tbl_b.push_back(mk("en_load",     1, 1, 0, 3'd1, 8'h11, 8'h00, 1, 8'h02,  1, 8'h11));
        tbl_b.push_back(mk("en_off",      0, 1, 0, 3'd0, 8'h99, 8'hFF, 0, 8'h00,  0, 8'h00));
        tbl_b.push_back(mk("en_off_bc",   0, 1, 1, 3'd0, 8'h99, 8'hFF, 0, 8'h00,  1, 8'h11));

        rst_n = 1'b0;
        en = 0; in_valid = 0; in_bcast = 0; in_sel = '0; in_data = '0; out_ready = '0;
        d6_en = 0; d6_in_valid = 0; d6_in_bcast = 0; d6_in_sel = '0; d6_in_data = '0; d6_out_ready = '0;
        #3;
        check("por out_valid", 64'(out_valid), 64'h0);
        check("por out_data", out_data, 64'h0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        foreach (tbl_a[i]) run_vec(tbl_a[i]);

        // Mid-cycle asynchronous reset with every slot full and stuck.
        in_valid = 1; in_bcast = 0; in_sel = 3'd0; out_ready = 8'h00; en = 1;
        #2 rst_n = 1'b0;
        #1;
        check("rst out_valid", 64'(out_valid), 64'h0);
        check("rst out_data", out_data, 64'h0);
        check("rst drop_count", 64'(drop_count), 64'h0);
        check("rst in_ready", 64'(in_ready), 64'h0);
        @(posedge clk); #1;
        check("rst hold out_valid", 64'(out_valid), 64'h0);
        rst_n = 1'b1; in_valid = 0;
        @(posedge clk); #1;

        foreach (tbl_b[i]) run_vec(tbl_b[i]);

        // Throughput: 100 words to channel 0 on consecutive cycles.
        en = 1; in_bcast = 0; in_sel = 3'd0; out_ready = 8'hFF; acc = 0;
        for (int i = 0; i < 100; i++) begin
            in_valid = 1; in_data = 8'(i);
            #2;
            if (in_valid && in_ready) acc++;
            @(posedge clk); #1;
            check($sformatf("stream word %0d", i), 64'(out_data[7:0]), 64'(i));
        end
        check("stream accepts", 64'(acc), 64'd100);
        in_valid = 0;
        @(posedge clk); #1;
        check("stream drained", 64'(out_valid), 64'h0);

        // Drops on the N=6 instance; slot 0 held full throughout.
        d6_en = 1; d6_out_ready = 6'h00; d6_in_valid = 1; d6_in_sel = 3'd0; d6_in_data = 8'h66;
        #2;
        check("d6 load ready", 64'(d6_in_ready), 64'h1);
        @(posedge clk); #1;
        check("d6 load valid", 64'(d6_out_valid), 64'h01);
        d6_in_sel = 3'd0; d6_in_data = 8'h67;
        #2;
        check("d6 stall ready", 64'(d6_in_ready), 64'h0);
        d6_in_sel = 3'd7; d6_in_data = 8'h77;
        for (int k = 1; k <= 3; k++) begin
            #1;
            check($sformatf("drop%0d ready", k), 64'(d6_in_ready), 64'h1);
            @(posedge clk); #1;
            check($sformatf("drop%0d pulse", k), 64'(d6_drop_pulse), 64'h1);
            check($sformatf("drop%0d count", k), 64'(d6_drop_count), 64'(k));
            check($sformatf("drop%0d valid", k), 64'(d6_out_valid), 64'h01);
        end
        d6_in_valid = 0;
        @(posedge clk); #1;
        check("drop pulse end", 64'(d6_drop_pulse), 64'h0);
        check("drop count final", 64'(d6_drop_count), 64'd3);
        check("drop data kept", 64'(d6_out_data[7:0]), 64'h66);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/stream_demux.md
# stream_demux

Parametrised, registered 1-to-N stream demultiplexer with valid/ready handshaking and per-channel one-entry output buffers. It routes a data word from one input stream to the output channel chosen by `in_sel`, or to all channels in broadcast mode. It supersedes the combinational 1:8 demux in datapaths where the input must be backpressured and the outputs must be registered.

## Interface
Parameters:
- `WIDTH`, 8, data word width in bits (≥1)
- `N`, 8, number of output channels (2..64)
- `SEL_W`, `$clog2(N)`, select width; derived, not overridden

Ports:
- `clk`  in  1  rising-edge clock; the only clock
- `rst_n`  in  1  reset, asynchronous assert, active-low
- `en`  in  1  global enable; when low, no input word is accepted
- `in_valid`  in  1  input word present
- `in_ready`  out  1  block can accept the input word this cycle
- `in_data`  in  WIDTH  input word
- `in_sel`  in  SEL_W  target channel
- `in_bcast`  in  1  1 = write the word to all N channels; `in_sel` is ignored
- `out_valid`  out  N  per-channel output valid
- `out_ready`  in  N  per-channel downstream ready
- `out_data`  out  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- `drop_pulse`  out  1  one-cycle pulse when a word with `in_sel >= N` is accepted and discarded
- `drop_count`  out  16  saturating count of discarded words

## Operation
- Each channel has one buffer slot. The slot can take a word in a cycle when it is free: `!out_valid[i] || out_ready[i]`.
- `in_ready` is combinational:
  - `en && in_bcast && all slots free`, or
  - `en && !in_bcast && (in_sel >= N || slot_free[in_sel])`.
- Accept = `in_valid && in_ready`.
- On accept in unicast mode with `in_sel < N`: load `in_data` into slot `in_sel` and set its valid.
- On accept in broadcast mode: load all N slots in the same cycle.
- On accept with `in_sel >= N` (only possible when N is not a power of 2): discard the word, pulse `drop_pulse`, and increment `drop_count`. The count saturates at 16'hFFFF.
- Channel handshake: when `out_valid[i] && out_ready[i]` and no new load, clear valid. When both the handshake and a new load occur in the same cycle, load the new word and keep valid high, so back-to-back throughput is one word per cycle per channel.
- `out_data[i]` holds its value while `out_valid[i]` is high and not consumed. It holds the last word after it is consumed.
- `en` falling does not flush the slots; buffered words still drain.
- `in_ready` must not depend on `in_valid`. `out_valid` must not depend on `out_ready`.

## Timing
- Reset (`rst_n` low, asynchronous) drives these values immediately and holds them until the first rising edge after `rst_n` goes high:
  - `out_valid` = 0
  - `out_data` = 0
  - `drop_pulse` = 0
  - `drop_count` = 0
- `in_ready` = 0 while `rst_n` is low.
- Reset mid-transfer discards all buffered words. No partial broadcast survives.
- Latency: a word accepted at edge k shows on `out_valid`/`out_data` after edge k, so it is visible in cycle k+1.
- A word can be accepted in the same cycle the target slot drains (pass-through of ready, zero bubble).
- `drop_pulse` is high for exactly the cycle after the accepting edge.
- Simultaneous events:
  - Broadcast while any slot is full with its `out_ready` low: `in_ready` = 0, and nothing is written to any slot (all-or-nothing).
  - Unicast to a full, non-draining channel: stall. Other channels keep draining independently.

## Structure
- Shared package `stream_demux_pkg` holds:
  - `localparam DROP_CNT_W = 16`
  - a `sel_in_range` function (`sel < N`)
  - the default parameter constants
- One sub-module, `demux_slot`. It is a single-entry valid/data register with a `load` input, `data_in`, `out_valid`, `out_ready` and a `free` output. `stream_demux` instantiates it N times in a generate loop.
- Top-level logic: ready/accept decode, load-enable vector, and the drop counter.

## Test plan
- **Reset:** assert `rst_n` = 0 mid-cycle with slots full. Required: `out_valid` = 0, `out_data` = 0, `drop_count` = 0 immediately, and `in_ready` = 0.
- **Unicast sweep:** N = 8, all `out_ready` = 1, send `in_data` = 8'hA0+i with `in_sel` = i for i = 0..7 on consecutive cycles. Required: `out_valid` is one-hot on bit i one cycle after each accept, and `out_data[i]` = 8'hA0+i.
- **Backpressure:** `out_ready[3]` = 0, send two words to channel 3. Required: the first is held, `in_ready` drops for `in_sel` = 3, and a word to channel 5 is still accepted. When `out_ready[3]` rises, the second word loads in the same cycle.
- **Broadcast:** `in_bcast` = 1, `in_data` = 8'h5A, all slots free. Required: `out_valid` = 8'hFF and every channel = 8'h5A in the next cycle. Repeat with `out_ready[2]` = 0 and slot 2 full. Required: `in_ready` = 0 and no slot changes.
- **Drop:** N = 6, `in_sel` = 3'd7, accept 3 words. Required: 3 `drop_pulse` cycles, `drop_count` = 3, and `out_valid` unchanged.
- **Enable/throughput:** `en` = 0 with `in_valid` = 1. Required: `in_ready` = 0 and buffered words still drain. Then with `en` = 1, stream 100 words to channel 0 with `out_ready[0]` = 1. Required: 100 accepts in 100 consecutive cycles.
